fizzbuzz_rx: RTL and testbench
==============================

Name: fizzbuzz_rx

Overview:
Receiver/checker for the fizz/buzz/fizzbuzz flag stream produced by the team's fizzbuzz counter generator. It acquires phase on a fizzbuzz symbol and reconstructs the generator's counter value. It then predicts every following symbol and reports lock status, the recovered count and mismatches. It sits downstream of the generator, or of any link carrying its flags, as a self-check and monitor block.

Parameters:
FIZZ, 3, fizz divisor (>=2)
BUZZ, 5, buzz divisor (>=2)
MAX_CYCLES, 100, generator wrap: count runs 0..MAX_CYCLES-1 then 0
LOCK_LEN, 4, consecutive matching samples (including the acquire sample) needed to declare lock (>=1)
ERRW, 8, width of saturating error counter

Ports:
clk  in  1  clock, all logic on rising edge
resetn  in  1  synchronous, active-low reset
in_valid  in  1  sample qualifier; flags are consumed only when high
in_fizz  in  1  received fizz flag
in_buzz  in  1  received buzz flag
in_fizzbuzz  in  1  received fizzbuzz flag
locked  out  1  phase locked, registered
count  out  CW  recovered counter value of the last accepted sample; CW = $clog2(MAX_CYCLES)
mismatch  out  1  one-cycle pulse: accepted sample differed from prediction while LOCKED, or sample was illegal
err_cnt  out  ERRW  saturating count of mismatch pulses

Behaviour:
- Reset (resetn=0 at posedge): state=SEARCH, locked=0, count=0, mismatch=0, err_cnt=0, run=0, residues r3=r5=0. Reset mid-operation aborts everything on that edge.
- The block does nothing when in_valid=0: state, count and run hold, and mismatch=0 that cycle.
- All outputs are registered and reflect the sample accepted on the previous edge (latency 1).
- Legal symbol: in_fizzbuzz == (in_fizz & in_buzz). An illegal accepted sample pulses mismatch and increments err_cnt in any state, then is treated as a prediction failure.
- Prediction uses nxt = (count==MAX_CYCLES-1) ? 0 : count+1.
  - r3 and r5 are residue counters, mod FIZZ and mod BUZZ. Both advance with count and both force to 0 when count wraps. No % operator is used on count.
  - Expected flags: fizz = (nxt_r3==0), buzz = (nxt_r5==0), fizzbuzz = both.
- SEARCH:
  - Accepted legal sample with in_fizzbuzz=1 sets count=0, r3=r5=0 and run=1. Next state is LOCKED if LOCK_LEN==1, otherwise VERIFY.
  - Any other legal sample is ignored: no count, no error.
- VERIFY:
  - Match sets count=nxt and residues to their next values, and increments run. When run reaches LOCK_LEN, go to LOCKED and set locked=1.
  - Mismatch goes to SEARCH without pulsing mismatch (only an illegal symbol pulses). If the mismatching sample is itself a legal fizzbuzz, re-acquire on it immediately: count=0, run=1, VERIFY.
- LOCKED:
  - Match advances count and residues.
  - Mismatch pulses mismatch, increments err_cnt, clears locked and goes to SEARCH. The same legal-fizzbuzz re-acquire rule applies.
- Ambiguity: acquire assumes count 0 on any fizzbuzz symbol, so a false acquire (e.g. real count 15) matches until the wrap region. A false acquire detected in VERIFY is silent; one detected after lock reports a mismatch. This is intended behaviour.
- err_cnt saturates at 2^ERRW-1.

Optional Feature:
FIZZBUZZ_RX_FLYWHEEL_EN
- Defined:
  - In LOCKED, a single mismatch pulses mismatch and increments err_cnt, but locked stays 1. count and residues advance along the prediction (flywheel), and a miss flag is set.
  - A second consecutive mismatch drops to SEARCH as above. Any match clears the miss flag.
  - Illegal symbols follow the same rule.
- Undefined: the miss flag does not exist and any LOCKED mismatch drops lock immediately.

Test Plan:
- Generator and rx released from reset together, continuous in_valid, LOCK_LEN=4 -> locked=1 the cycle after the sample for count 3, count=3; count follows 99->0 wrap with no mismatch over 300 cycles.
- Stream started at generator count 7 -> samples 7..14 ignored; acquire at 15 (count=0), lock after LOCK_LEN matches; mismatch=1 and err_cnt=1 at the real wrap (real 99->0, rx predicts 85).
- Locked stream with in_fizz forced 1 at count 4 (illegal: fizzbuzz=0 while fizz&buzz=1 is false? use in_fizz=1,in_buzz=1,in_fizzbuzz=0) -> mismatch pulse, err_cnt+1, locked=0 (flywheel off), re-lock at next fizzbuzz (count 15 treated as 0).
- in_valid toggled 1,0,1,0 during locked operation -> count advances only on valid samples, no mismatch.
- resetn low for one cycle while locked at count 42 -> next cycle locked=0, count=0, err_cnt=0, state SEARCH.
- FIZZBUZZ_RX_FLYWHEEL_EN defined, single corrupted sample at count 20 -> mismatch=1, locked stays 1, count=21 next; two consecutive corrupted samples -> locked=0.

Source files
------------

// File: rtl/fizzbuzz_rx.sv
`default_nettype none
// ============================================================================
// Module   : fizzbuzz_rx
// Purpose  : Receiver/checker for the fizz/buzz/fizzbuzz flag stream of the
//            fizzbuzz counter generator. Acquires phase on a fizzbuzz symbol
//            (assumed count 0), verifies LOCK_LEN consecutive predictions,
//            then tracks the recovered count and flags every deviation.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1     clock, rising edge
//   resetn       in   1     synchronous active-low reset
//   in_valid     in   1     sample qualifier
//   in_fizz      in   1     received fizz flag
//   in_buzz      in   1     received buzz flag
//   in_fizzbuzz  in   1     received fizzbuzz flag
//   locked       out  1     phase locked (registered)
//   count        out  CW    recovered count of the last accepted sample
//   mismatch     out  1     one-cycle error pulse
//   err_cnt      out  ERRW  saturating count of mismatch pulses
// ----------------------------------------------------------------------------
// Optional feature macro: FIZZBUZZ_RX_FLYWHEEL_EN
//   When defined, a single mismatch while locked is tolerated: the block
//   flywheels along its prediction and only a second consecutive mismatch
//   drops lock.
// ============================================================================
module fizzbuzz_rx #(
  parameter int FIZZ       = 3,
  parameter int BUZZ       = 5,
  parameter int MAX_CYCLES = 100,
  parameter int LOCK_LEN   = 4,
  parameter int ERRW       = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_valid,
  input  logic                          in_fizz,
  input  logic                          in_buzz,
  input  logic                          in_fizzbuzz,
  output logic                          locked,
  output logic [$clog2(MAX_CYCLES)-1:0] count,
  output logic                          mismatch,
  output logic [ERRW-1:0]               err_cnt
);

  localparam int CW  = $clog2(MAX_CYCLES);
  localparam int R3W = $clog2(FIZZ);
  localparam int R5W = $clog2(BUZZ);
  localparam int RW  = $clog2(LOCK_LEN + 1);

  localparam logic [CW-1:0]   CNT_LAST = CW'(MAX_CYCLES - 1);
  localparam logic [R3W-1:0]  R3_LAST  = R3W'(FIZZ - 1);
  localparam logic [R5W-1:0]  R5_LAST  = R5W'(BUZZ - 1);
  localparam logic [RW-1:0]   RUN_LAST = RW'(LOCK_LEN - 1);
  localparam logic [ERRW-1:0] ERR_MAX  = {ERRW{1'b1}};
  // With LOCK_LEN==1 the acquire sample alone is enough to lock.
  localparam bit              ACQ_LOCK = (LOCK_LEN == 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t         state;
  logic [R3W-1:0] r3;
  logic [R5W-1:0] r5;
  logic [RW-1:0]  run;
`ifdef FIZZBUZZ_RX_FLYWHEEL_EN
  logic           miss;
`endif

  // Prediction of the next sample. The residues track count mod FIZZ/BUZZ
  // incrementally and are forced to zero together with the count wrap, so
  // no divider is needed.
  logic           wrap;
  logic [CW-1:0]  nxt_count;
  logic [R3W-1:0] nxt_r3;
  logic [R5W-1:0] nxt_r5;
  logic           exp_fizz;
  logic           exp_buzz;
  logic           legal;
  logic           match;
  logic           acquire;
  logic           pulse;

  assign wrap      = (count == CNT_LAST);
  assign nxt_count = wrap ? '0 : count + CW'(1);
  assign nxt_r3    = (wrap || r3 == R3_LAST) ? '0 : r3 + R3W'(1);
  assign nxt_r5    = (wrap || r5 == R5_LAST) ? '0 : r5 + R5W'(1);
  assign exp_fizz  = (nxt_r3 == '0);
  assign exp_buzz  = (nxt_r5 == '0);

  assign legal   = (in_fizzbuzz == (in_fizz & in_buzz));
  // For a legal symbol fizzbuzz follows from fizz and buzz, so comparing
  // those two is a full comparison.
  assign match   = legal & (in_fizz == exp_fizz) & (in_buzz == exp_buzz);
  assign acquire = legal & in_fizzbuzz;

  // Illegal symbols are reported in every state; prediction misses only
  // once locked (a failed verification is silent).
  assign pulse   = in_valid & (~legal | ((state == LOCKED) & ~match));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= SEARCH;
      locked   <= 1'b0;
      count    <= '0;
      r3       <= '0;
      r5       <= '0;
      run      <= '0;
      mismatch <= 1'b0;
      err_cnt  <= '0;
`ifdef FIZZBUZZ_RX_FLYWHEEL_EN
      miss     <= 1'b0;
`endif
    end else begin
      mismatch <= pulse;
      if (pulse && err_cnt != ERR_MAX) begin
        err_cnt <= err_cnt + ERRW'(1);
      end

      if (in_valid) begin
        case (state)
          SEARCH: begin
            if (acquire) begin
              count  <= '0;
              r3     <= '0;
              r5     <= '0;
              run    <= RW'(1);
              state  <= ACQ_LOCK ? LOCKED : VERIFY;
              locked <= ACQ_LOCK;
            end
          end

          VERIFY: begin
            if (match) begin
              count <= nxt_count;
              r3    <= nxt_r3;
              r5    <= nxt_r5;
              run   <= run + RW'(1);
              if (run == RUN_LAST) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else if (acquire) begin
              // The offending symbol is itself a fizzbuzz: restart on it.
              count  <= '0;
              r3     <= '0;
              r5     <= '0;
              run    <= RW'(1);
              state  <= ACQ_LOCK ? LOCKED : VERIFY;
              locked <= ACQ_LOCK;
            end else begin
              state <= SEARCH;
            end
          end

          LOCKED: begin
            if (match) begin
              count <= nxt_count;
              r3    <= nxt_r3;
              r5    <= nxt_r5;
`ifdef FIZZBUZZ_RX_FLYWHEEL_EN
              miss  <= 1'b0;
            end else if (!miss) begin
              // First miss: coast along the prediction and stay locked.
              count <= nxt_count;
              r3    <= nxt_r3;
              r5    <= nxt_r5;
              miss  <= 1'b1;
`endif
            end else begin
`ifdef FIZZBUZZ_RX_FLYWHEEL_EN
              miss <= 1'b0;
`endif
              if (acquire) begin
                count  <= '0;
                r3     <= '0;
                r5     <= '0;
                run    <= RW'(1);
                state  <= ACQ_LOCK ? LOCKED : VERIFY;
                locked <= ACQ_LOCK;
              end else begin
                state  <= SEARCH;
                locked <= 1'b0;
              end
            end
          end

          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fizzbuzz_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fizzbuzz_rx
// Purpose  : Self-checking bench for fizzbuzz_rx. A vector table covers the
//            acquire/verify/lock sequence; directed generator streams and a
//            randomized stream are checked against a behavioural model that
//            derives expected flags from the count with plain modulo math.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fizzbuzz_rx;

  localparam int FIZZ       = 3;
  localparam int BUZZ       = 5;
  localparam int MAX_CYCLES = 100;
  localparam int LOCK_LEN   = 4;
  localparam int ERRW       = 8;
  localparam int CW         = $clog2(MAX_CYCLES);
  localparam int ERR_SAT    = (1 << ERRW) - 1;
`ifdef FIZZBUZZ_RX_FLYWHEEL_EN
  localparam bit FLY = 1'b1;
`else
  localparam bit FLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic          in_fizz;
  logic          in_buzz;
  logic          in_fizzbuzz;
  logic          locked;
  logic [CW-1:0] count;
  logic          mismatch;
  logic [ERRW-1:0] err_cnt;

  always #5 clk = ~clk;

  fizzbuzz_rx #(
    .FIZZ       (FIZZ),
    .BUZZ       (BUZZ),
    .MAX_CYCLES (MAX_CYCLES),
    .LOCK_LEN   (LOCK_LEN),
    .ERRW       (ERRW)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_fizz     (in_fizz),
    .in_buzz     (in_buzz),
    .in_fizzbuzz (in_fizzbuzz),
    .locked      (locked),
    .count       (count),
    .mismatch    (mismatch),
    .err_cnt     (err_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0=searching, 1=verifying, 2=locked.
  int m_phase;
  int m_count;
  int m_run;
  int m_err;
  bit m_miss;
  bit m_mm;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_acquire();
    m_count = 0;
    m_run   = 1;
    m_phase = (LOCK_LEN == 1) ? 2 : 1;
  endtask

  task automatic model_step(input bit v, input bit f, input bit b, input bit fb);
    int nxt;
    bit legal;
    bit good;
    bit acq;
    m_mm = 1'b0;
    if (!v) return;
    legal = (fb == (f & b));
    nxt   = (m_count + 1) % MAX_CYCLES;
    good  = legal && (f == (nxt % FIZZ == 0)) && (b == (nxt % BUZZ == 0));
    acq   = legal && fb;
    if (!legal) m_mm = 1'b1;
    if (m_phase == 0) begin
      if (acq) model_acquire();
    end else if (good) begin
      m_count = nxt;
      m_miss  = 1'b0;
      if (m_phase == 1) begin
        m_run++;
        if (m_run == LOCK_LEN) m_phase = 2;
      end
    end else if (m_phase == 2 && FLY && !m_miss) begin
      m_mm    = 1'b1;
      m_count = nxt;
      m_miss  = 1'b1;
    end else begin
      if (m_phase == 2) m_mm = 1'b1;
      m_miss  = 1'b0;
      m_phase = 0;
      if (acq) model_acquire();
    end
    if (m_mm && m_err < ERR_SAT) m_err++;
  endtask

  // Apply one sample, let one edge pass, compare all outputs to the model.
  task automatic send(input bit v, input bit f, input bit b, input bit fb, input string tag);
    in_valid    = v;
    in_fizz     = f;
    in_buzz     = b;
    in_fizzbuzz = fb;
    @(posedge clk);
    #1;
    model_step(v, f, b, fb);
    check({tag, " locked"},   int'(locked),   int'(m_phase == 2));
    check({tag, " count"},    int'(count),    m_count);
    check({tag, " mismatch"}, int'(mismatch), int'(m_mm));
    check({tag, " err_cnt"},  int'(err_cnt),  m_err);
  endtask

  // Correct generator symbol for count value g.
  task automatic gen(input int g, input string tag);
    send(1'b1, (g % FIZZ) == 0, (g % BUZZ) == 0,
         ((g % FIZZ) == 0) && ((g % BUZZ) == 0), tag);
  endtask

  task automatic do_reset(input bit v, input bit f, input bit b, input bit fb, input string tag);
    resetn      = 1'b0;
    in_valid    = v;
    in_fizz     = f;
    in_buzz     = b;
    in_fizzbuzz = fb;
    @(posedge clk);
    #1;
    resetn   = 1'b1;
    in_valid = 1'b0;
    m_phase = 0;
    m_count = 0;
    m_run   = 0;
    m_err   = 0;
    m_miss  = 1'b0;
    m_mm    = 1'b0;
    check({tag, " locked"},   int'(locked),   0);
    check({tag, " count"},    int'(count),    0);
    check({tag, " mismatch"}, int'(mismatch), 0);
    check({tag, " err_cnt"},  int'(err_cnt),  0);
  endtask

  typedef struct {
    bit v;
    bit f;
    bit b;
    bit fb;
    bit exp_locked;
    int exp_count;
    bit exp_mm;
    int exp_err;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int g;
    bit seen_wrap;

    // valid, fizz, buzz, fizzbuzz | locked, count, mismatch, err_cnt
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0}; // legal buzz ignored
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1}; // illegal in search
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1}; // acquire
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b0, 1}; // fourth match locks
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3, 1'b0, 1}; // invalid holds
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0, 1};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5, 1'b0, 1};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6, 1'b0, 1};

    resetn = 1'b0;
    in_valid = 1'b0;
    in_fizz = 1'b0;
    in_buzz = 1'b0;
    in_fizzbuzz = 1'b0;
    @(posedge clk);
    #1;
    do_reset(1'b0, 1'b0, 1'b0, 1'b0, "reset0");

    // Table-driven acquire/lock sequence.
    for (int i = 0; i < 10; i++) begin
      in_valid    = tbl[i].v;
      in_fizz     = tbl[i].f;
      in_buzz     = tbl[i].b;
      in_fizzbuzz = tbl[i].fb;
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d locked", i),   int'(locked),   int'(tbl[i].exp_locked));
      check($sformatf("tbl%0d count", i),    int'(count),    tbl[i].exp_count);
      check($sformatf("tbl%0d mismatch", i), int'(mismatch), int'(tbl[i].exp_mm));
      check($sformatf("tbl%0d err_cnt", i),  int'(err_cnt),  tbl[i].exp_err);
    end

    // Aligned start, continuous stream through several wraps.
    do_reset(1'b0, 1'b0, 1'b0, 1'b0, "reset1");
    for (int k = 0; k < 300; k++) begin
      gen(k % MAX_CYCLES, "aligned");
      if (k == 3) begin
        check("aligned lock at 3", int'(locked), 1);
        check("aligned count at 3", int'(count), 3);
      end
    end
    check("aligned no errors", int'(err_cnt), 0);

    // Start at count 7: false acquire at 15, detected at the real wrap.
    do_reset(1'b0, 1'b0, 1'b0, 1'b0, "reset2");
    seen_wrap = 1'b0;
    for (int k = 0; k < 110; k++) begin
      g = (7 + k) % MAX_CYCLES;
      gen(g, "late");
      if (k == 11) check("late locked after 4", int'(locked), 1);
      if (g == 0 && !seen_wrap) begin
        seen_wrap = 1'b1;
        check("late wrap mismatch", int'(mismatch), 1);
        check("late wrap err_cnt", int'(err_cnt), 1);
      end
    end

    // Illegal symbol while locked at count 4.
    do_reset(1'b0, 1'b0, 1'b0, 1'b0, "reset3");
    for (int k = 0; k < 4; k++) gen(k, "illegal pre");
    send(1'b1, 1'b1, 1'b1, 1'b0, "illegal sym");
    check("illegal mismatch", int'(mismatch), 1);
    check("illegal locked", int'(locked), int'(FLY));
    for (int k = 5; k < 40; k++) gen(k, "illegal post");
    check("illegal relocked", int'(locked), 1);

    // in_valid toggling while locked.
    do_reset(1'b0, 1'b0, 1'b0, 1'b0, "reset4");
    for (int k = 0; k < 10; k++) gen(k, "toggle pre");
    for (int k = 10; k < 30; k++) begin
      gen(k, "toggle v");
      send(1'b0, 1'b1, 1'b1, 1'b0, "toggle idle");
    end
    check("toggle count", int'(count), 29);

    // Randomized stream with corruption, idles and phase jumps.
    do_reset(1'b0, 1'b0, 1'b0, 1'b0, "reset5");
    g = 0;
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 20) begin
        send(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), "rnd idle");
      end else if (r < 26) begin
        send(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), "rnd noise");
        g = (g + 1) % MAX_CYCLES;
      end else if (r < 28) begin
        g = int'($urandom_range(0, MAX_CYCLES - 1));
        gen(g, "rnd jump");
        g = (g + 1) % MAX_CYCLES;
      end else begin
        gen(g, "rnd gen");
        g = (g + 1) % MAX_CYCLES;
      end
    end

    // Saturate the error counter with illegal symbols.
    for (int i = 0; i < 300; i++) send(1'b1, 1'b1, 1'b1, 1'b0, "sat");
    check("sat err_cnt", int'(err_cnt), ERR_SAT);

    // Reset while locked at 42 (also clears the saturated counter).
    do_reset(1'b0, 1'b0, 1'b0, 1'b0, "reset6");
    for (int k = 0; k <= 42; k++) gen(k, "r42 pre");
    check("r42 locked", int'(locked), 1);
    check("r42 count", int'(count), 42);
    send(1'b1, 1'b1, 1'b0, 1'b0, "r42 illegal");
    do_reset(1'b1, 1'b1, 1'b0, 1'b0, "r42 reset");

`ifdef FIZZBUZZ_RX_FLYWHEEL_EN
    // Flywheel: one corrupted sample tolerated, two consecutive drop lock.
    do_reset(1'b0, 1'b0, 1'b0, 1'b0, "reset7");
    for (int k = 0; k < 20; k++) gen(k, "fly pre");
    send(1'b1, 1'b0, 1'b0, 1'b0, "fly miss1");
    check("fly miss1 mismatch", int'(mismatch), 1);
    check("fly miss1 locked", int'(locked), 1);
    check("fly miss1 count", int'(count), 20);
    gen(21, "fly recover");
    check("fly recover count", int'(count), 21);
    check("fly recover mismatch", int'(mismatch), 0);
    for (int k = 22; k < 30; k++) gen(k, "fly mid");
    send(1'b1, 1'b0, 1'b0, 1'b0, "fly miss2a");
    check("fly miss2a locked", int'(locked), 1);
    send(1'b1, 1'b1, 1'b0, 1'b0, "fly miss2b");
    check("fly miss2b mismatch", int'(mismatch), 1);
    check("fly miss2b locked", int'(locked), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
